// File: rtl/set_assoc_cache.sv
// Set-associative write-back/write-allocate cache with true-LRU ages and a word-serial memory port.
// Optional CACHE_PERF_CNT_EN adds hit_count/miss_count/wb_count outputs.
module set_assoc_cache #(
  parameter int ADDR_SIZE       = 32,
  parameter int NUM_SETS        = 16,
  parameter int NUM_WAYS        = 4,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [3:0]           req_wstrb,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 mem_valid,
  output logic                 mem_write,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_rdata
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count,
  output logic [31:0]          wb_count
`endif
);
  localparam int WOFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int TAG_W  = ADDR_SIZE - 2 - WOFF_W - SET_W;
  localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(WORDS_PER_BLOCK - 1);
  localparam logic [WAY_W-1:0]  OLDEST    = WAY_W'(NUM_WAYS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_REFILL, S_RESPOND} state_e;

  typedef struct packed {
    logic              write;
    logic [TAG_W-1:0]  tag;
    logic [SET_W-1:0]  set;
    logic [WOFF_W-1:0] word;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
  } req_t;

  state_e            state_q;
  req_t              req_q;
  logic [WOFF_W-1:0] beat_q;
  logic [WAY_W-1:0]  victim_q;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0]            valid_q, dirty_q;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAY_W-1:0] age_q;
  logic [TAG_W-1:0] tag_q  [NUM_SETS][NUM_WAYS];
  logic [31:0]      data_q [NUM_SETS][NUM_WAYS][WORDS_PER_BLOCK];

  logic [NUM_WAYS-1:0]             lane_hit;
  logic [NUM_WAYS-1:0][WAY_W-1:0]  age_nxt;
  logic                            hit, vict_found, touch_en;
  logic [WAY_W-1:0]                hit_way, vict_way, touch_way;
  logic [WAY_W-1:0]                age_t;
  logic [31:0]                     cur_word, merged;
  logic                            unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (lane_hit[w] && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
  end

  // Prefer the lowest invalid way; a full set evicts the oldest age.
  always_comb begin
    vict_found = 1'b0;
    vict_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (!valid_q[req_q.set][w] && !vict_found) begin
        vict_found = 1'b1;
        vict_way   = WAY_W'(w);
      end
    if (!vict_found)
      for (int w = 0; w < NUM_WAYS; w++)
        if (age_q[req_q.set][w] == OLDEST) vict_way = WAY_W'(w);
  end

  assign touch_en  = (state_q == S_LOOKUP && hit) || (state_q == S_RESPOND);
  assign touch_way = (state_q == S_RESPOND) ? victim_q : hit_way;
  assign age_t     = age_q[req_q.set][touch_way];
  assign cur_word  = data_q[req_q.set][touch_way][req_q.word];

  always_comb begin
    merged = cur_word;
    for (int b = 0; b < 4; b++)
      if (req_q.wstrb[b]) merged[8*b +: 8] = req_q.wdata[8*b +: 8];
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_lane
    set_assoc_cache_lane #(.TAG_W(TAG_W), .AGE_W(WAY_W)) u_lane (
      .vld_i    (valid_q[req_q.set][w]),
      .tag_i    (tag_q[req_q.set][w]),
      .req_tag_i(req_q.tag),
      .age_i    (age_q[req_q.set][w]),
      .age_t_i  (age_t),
      .touch_i  (touch_way == WAY_W'(w)),
      .hit_o    (lane_hit[w]),
      .age_nxt_o(age_nxt[w])
    );
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = touch_en;
  assign resp_rdata = touch_en ? cur_word : 32'h0;
  assign mem_valid  = (state_q == S_WB) || (state_q == S_REFILL);
  assign mem_write  = (state_q == S_WB);
  assign mem_wdata  = (state_q == S_WB) ? data_q[req_q.set][victim_q][beat_q] : 32'h0;

  always_comb begin
    mem_addr = '0;
    if (state_q == S_WB)
      mem_addr = {tag_q[req_q.set][victim_q], req_q.set, beat_q, 2'b00};
    else if (state_q == S_REFILL)
      mem_addr = {req_q.tag, req_q.set, beat_q, 2'b00};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      beat_q   <= '0;
      victim_q <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else begin
      if (touch_en) begin
        age_q[req_q.set] <= age_nxt;
        if (req_q.write) dirty_q[req_q.set][touch_way] <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: if (req_valid) begin
          req_q.write <= req_write;
          req_q.tag   <= req_addr[ADDR_SIZE-1 -: TAG_W];
          req_q.set   <= req_addr[2+WOFF_W +: SET_W];
          req_q.word  <= req_addr[2 +: WOFF_W];
          req_q.wdata <= req_wdata;
          req_q.wstrb <= req_wstrb;
          state_q     <= S_LOOKUP;
        end
        S_LOOKUP: if (hit) begin
          state_q <= S_IDLE;
        end else begin
          victim_q <= vict_way;
          beat_q   <= '0;
          state_q  <= (valid_q[req_q.set][vict_way] && dirty_q[req_q.set][vict_way])
                      ? S_WB : S_REFILL;
        end
        S_WB: if (mem_ready) begin
          beat_q <= beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_q <= S_REFILL;
        end
        S_REFILL: if (mem_ready) begin
          beat_q <= beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            valid_q[req_q.set][victim_q] <= 1'b1;
            dirty_q[req_q.set][victim_q] <= 1'b0;
            state_q <= S_RESPOND;
          end
        end
        S_RESPOND: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  // Tag/data storage carries no reset; valid bits gate its use.
  always_ff @(posedge clk) begin
    if (state_q == S_REFILL && mem_ready) begin
      data_q[req_q.set][victim_q][beat_q] <= mem_rdata;
      if (beat_q == LAST_BEAT) tag_q[req_q.set][victim_q] <= req_q.tag;
    end
    if (touch_en && req_q.write)
      data_q[req_q.set][touch_way][req_q.word] <= merged;
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (state_q == S_LOOKUP) begin
        if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
        else     miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if (state_q == S_WB && mem_ready && beat_q == LAST_BEAT)
        wb_cnt_q <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`endif
endmodule

// Per-way tag compare and LRU age step for the touched way.
module set_assoc_cache_lane #(
  parameter int TAG_W = 24,
  parameter int AGE_W = 2
) (
  input  logic             vld_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic [AGE_W-1:0] age_i,
  input  logic [AGE_W-1:0] age_t_i,
  input  logic             touch_i,
  output logic             hit_o,
  output logic [AGE_W-1:0] age_nxt_o
);
  assign hit_o = vld_i && (tag_i == req_tag_i);

  always_comb begin
    age_nxt_o = age_i;
    if (touch_i)              age_nxt_o = '0;
    else if (age_i < age_t_i) age_nxt_o = age_i + 1'b1;
  end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache: a flat-memory + per-set recency-list model predicts
// responses and memory beats; monitors compare whatever the DUT presents.
`timescale 1ns/1ps
module tb_set_assoc_cache;
  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_write, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  set_assoc_cache dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {bit wr; logic [31:0] addr; logic [31:0] data;} beat_t;
  typedef struct {bit wr; bit hit; logic [31:0] rdata;} resp_t;

  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0, n_resp = 0, beat_cnt = 0;
  int n_hit = 0, n_miss = 0, n_wb = 0;
  bit mon_en = 0, rand_ready = 0, force_stall = 0, abort = 0, req_busy = 0;

  beat_t exp_beats[$];
  resp_t exp_resp[$];
  beat_t mb;
  resp_t mr;

  logic [31:0] mm [logic [31:0]];  // main memory as seen on the bus
  logic [31:0] sh [logic [31:0]];  // architectural memory as seen by the CPU
  int unsigned lt [16][4];         // per-set tags, most recent first
  bit          ld [16][4];
  int          lc [16];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mm.exists(a) ? mm[a] : 32'hA000_0000 + a;
  endfunction
  function automatic logic [31:0] srd(input logic [31:0] a);
    return sh.exists(a) ? sh[a] : 32'hA000_0000 + a;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s got nothing want event", nm);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 16; s++) lc[s] = 0;
    sh = mm;
    exp_beats.delete();
    exp_resp.delete();
  endtask

  task automatic model_req(input logic [31:0] a, input bit w, input logic [31:0] wd,
                           input logic [3:0] ws, output bit hit);
    int s, pos;
    int unsigned t, v;
    bit d;
    logic [31:0] wa, word;
    beat_t b;
    resp_t r;
    s = int'((a >> 4) & 32'hF);
    t = a >> 8;
    wa = a & ~32'h3;
    pos = -1;
    for (int i = 0; i < lc[s]; i++) if (lt[s][i] == t) pos = i;
    hit = (pos >= 0);
    if (hit) begin
      n_hit++;
      d = ld[s][pos] | w;
      for (int i = pos; i > 0; i--) begin lt[s][i] = lt[s][i-1]; ld[s][i] = ld[s][i-1]; end
    end else begin
      n_miss++;
      d = w;
      if (lc[s] == 4) begin
        v = lt[s][3];
        if (ld[s][3]) begin
          n_wb++;
          for (int k = 0; k < 4; k++) begin
            b.wr = 1; b.addr = (v << 8) | (s << 4) | (k << 2); b.data = srd(b.addr);
            exp_beats.push_back(b);
          end
        end
        lc[s] = 3;
      end
      for (int k = 0; k < 4; k++) begin
        b.wr = 0; b.addr = (t << 8) | (s << 4) | (k << 2); b.data = 0;
        exp_beats.push_back(b);
      end
      for (int i = lc[s]; i > 0; i--) begin lt[s][i] = lt[s][i-1]; ld[s][i] = ld[s][i-1]; end
      lc[s]++;
    end
    lt[s][0] = t;
    ld[s][0] = d;
    if (w) begin
      word = srd(wa);
      for (int k = 0; k < 4; k++) if (ws[k]) word[8*k +: 8] = wd[8*k +: 8];
      sh[wa] = word;
    end
    r.wr = w; r.hit = hit; r.rdata = srd(wa);
    exp_resp.push_back(r);
  endtask

  task automatic do_req(input logic [31:0] a, input bit w, input logic [31:0] wd, input logic [3:0] ws);
    bit hit, ok;
    int n0;
    req_busy = 1;
    model_req(a, w, wd, ws, hit);
    n0 = n_resp;
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = wd; req_wstrb = ws;
    ok = 0;
    for (int i = 0; i < 200 && !abort; i++) begin
      #1;
      if (req_ready) begin
        acc_cyc = cyc; ok = 1;
        @(posedge clk);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    req_valid = 0;
    if (!ok && !abort) fail("accept_timeout");
    for (int i = 0; i < 400 && n_resp == n0 && !abort; i++) @(negedge clk);
    if (n_resp == n0 && !abort) begin
      fail("resp_timeout");
      exp_beats.delete();
      exp_resp.delete();
    end
    req_busy = 0;
  endtask

  initial forever begin
    @(negedge clk);
    if (force_stall)     mem_ready = 0;
    else if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
    else                 mem_ready = 1;
    mem_rdata = mrd(mem_addr);
  end

  always @(negedge clk) begin
    #2;
    if (rst && mon_en && mem_valid) begin
      if (exp_beats.size() == 0) fail("unexpected_mem_valid");
      else if (mem_ready) begin
        mb = exp_beats.pop_front();
        check("beat_write", {31'b0, mem_write}, {31'b0, mb.wr});
        check("beat_addr", mem_addr, mb.addr);
        if (mb.wr) begin
          check("beat_wdata", mem_wdata, mb.data);
          mm[mem_addr] = mem_wdata;
        end
        beat_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst && mon_en && resp_valid) begin
      if (exp_resp.size() == 0) fail("unexpected_resp");
      else begin
        mr = exp_resp.pop_front();
        check("beats_done_at_resp", exp_beats.size(), 0);
        if (!mr.wr) check("load_data", resp_rdata, mr.rdata);
        if (mr.hit) check("hit_latency", cyc - acc_cyc, 1);
        else        check("miss_latency_ge6", {31'b0, (cyc - acc_cyc) >= 6}, 1);
      end
      n_resp++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    logic [31:0] a;
    rst = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;
    model_reset();
    #2 rst = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_resp_valid", {31'b0, resp_valid}, 0);
    check("rst_mem_valid", {31'b0, mem_valid}, 0);
    rst = 1;
    @(negedge clk); #1;
    check("post_rst_req_ready", {31'b0, req_ready}, 1);
    check("post_rst_resp_valid", {31'b0, resp_valid}, 0);
    check("post_rst_mem_valid", {31'b0, mem_valid}, 0);
    check("post_rst_mem_write", {31'b0, mem_write}, 0);
    check("post_rst_mem_addr", mem_addr, 0);
    check("post_rst_mem_wdata", mem_wdata, 0);
    mon_en = 1;

    // cold load, repeat hit, partial store then load
    b0 = beat_cnt;
    do_req(32'h104, 0, 0, 0);
    check("cold_beats", beat_cnt - b0, 4);
    do_req(32'h104, 0, 0, 0);
    do_req(32'h104, 1, 32'hDEAD_BEEF, 4'b0011);
    do_req(32'h104, 0, 0, 0);

    // set 0 fill with re-touch of tag 0 before the fifth tag
    do_req(32'h000, 0, 0, 0);
    do_req(32'h100, 0, 0, 0);
    do_req(32'h200, 0, 0, 0);
    do_req(32'h300, 0, 0, 0);
    do_req(32'h000, 0, 0, 0);
    b0 = beat_cnt;
    do_req(32'h400, 0, 0, 0);
    check("evict_wb_plus_refill_beats", beat_cnt - b0, 8);
    do_req(32'h000, 0, 0, 0);
    do_req(32'h104, 0, 0, 0);

`ifdef CACHE_PERF_CNT_EN
    check("hit_count", hit_count, n_hit);
    check("miss_count", miss_count, n_miss);
    check("wb_count", wb_count, n_wb);
`endif

    // memory stall in the middle of a refill
    b0 = beat_cnt;
    fork do_req(32'h2040, 0, 0, 0); join_none
    for (int i = 0; i < 50 && beat_cnt < b0 + 2; i++) begin @(negedge clk); #3; end
    force_stall = 1;
    repeat (10) begin
      @(negedge clk); #3;
      check("stall_mem_valid", {31'b0, mem_valid}, 1);
      check("stall_mem_write", {31'b0, mem_write}, 0);
      check("stall_mem_addr", mem_addr, 32'h2048);
      check("stall_req_ready", {31'b0, req_ready}, 0);
    end
    force_stall = 0;
    for (int i = 0; i < 100 && req_busy; i++) @(negedge clk);

    // asynchronous reset during refill beat 2
    b0 = beat_cnt;
    fork do_req(32'h3080, 0, 0, 0); join_none
    for (int i = 0; i < 50 && beat_cnt < b0 + 2; i++) begin @(negedge clk); #3; end
    @(posedge clk); #2;
    rst = 0;
    #1;
    check("async_rst_mem_valid", {31'b0, mem_valid}, 0);
    check("async_rst_mem_write", {31'b0, mem_write}, 0);
    check("async_rst_mem_addr", mem_addr, 0);
    check("async_rst_mem_wdata", mem_wdata, 0);
    check("async_rst_resp_valid", {31'b0, resp_valid}, 0);
    check("async_rst_req_ready", {31'b0, req_ready}, 1);
    abort = 1;
    mon_en = 0;
    for (int i = 0; i < 50 && req_busy; i++) @(negedge clk);
    model_reset();
    abort = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    mon_en = 1;
    b0 = beat_cnt;
    do_req(32'h3080, 0, 0, 0);
    check("post_reset_refill_beats", beat_cnt - b0, 4);

    // randomized traffic over a few sets and conflicting tags
    rand_ready = 1;
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 2) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 1) << 28);
      do_req(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
    end
    rand_ready = 0;
    repeat (3) @(negedge clk);
    check("resp_queue_drained", exp_resp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
